// File: rtl/scandoubler_sl.sv
// rtl/scandoubler_sl.sv - 15 kHz to 31 kHz line doubler with scanline dimming
//
// Captures one input line into one half of a two-line buffer while the other
// half is replayed twice at the output pixel rate. Output hsync is rebuilt
// from the hsync start/end counts measured on the input side.
//
// Ports:
//   clock, reset    system clock, asynchronous active-high reset
//   novga           1 = bypass native 15 kHz video with composite sync
//   sl_mode         scanline dimming on replay phase 1: 0 off, 1 75%, 2 50%, 3 25%
//   ice, oce        input / output pixel clock enables
//   isync, osync    {vsync, hsync}, active-high
//   irgb, orgb      CH channels of CW bits, channel 0 in the LSBs
//   ovf             sticky flag: an input line ran past 2**HCW pixels
//
// Build option: SCANLINE_DIM_EN enables the sl_mode dimming path; without it
// sl_mode is ignored and both replays of a line are identical.

module scandoubler_sl #(
    parameter int HCW = 9,
    parameter int CH  = 3,
    parameter int CW  = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             novga,
    input  logic [1:0]       sl_mode,
    input  logic             ice,
    input  logic [1:0]       isync,
    input  logic [CH*CW-1:0] irgb,
    input  logic             oce,
    output logic [1:0]       osync,
    output logic [CH*CW-1:0] orgb,
    output logic             ovf
);
    localparam int PW    = CH * CW;
    localparam int DEPTH = 2 ** (HCW + 1);
    localparam logic [HCW-1:0] HMAX = '1;
    localparam logic [HCW-1:0] HONE = {{(HCW-1){1'b0}}, 1'b1};

    logic [PW-1:0]  mem [DEPTH];

    // Input side
    logic           ihs_d;
    logic           ivs_d;
    logic           hs_pos;
    logic           hs_neg;
    logic           vs_neg;
    logic [HCW-1:0] ihcount;
    logic [HCW-1:0] ihs_beg;
    logic [HCW-1:0] ihs_end;
    logic           line;
    logic           sat;
    logic           ovf_evt;

    // Output side
    logic           ohs_d;
    logic           o_pos;
    logic [HCW-1:0] ohcount;
    logic           phase;
    logic           ohs;
    logic [PW-1:0]  brgb;
    logic [PW-1:0]  dim_rgb;

    assign hs_pos  = isync[0] & ~ihs_d;
    assign hs_neg  = ~isync[0] & ihs_d;
    assign vs_neg  = ~isync[1] & ivs_d;
    // The line is still running at the last addressable pixel.
    assign ovf_evt = (ihcount == HMAX) && !hs_neg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ihs_d   <= 1'b0;
            ivs_d   <= 1'b0;
            ihcount <= '0;
            ihs_beg <= '0;
            ihs_end <= '0;
            line    <= 1'b0;
            sat     <= 1'b0;
            ovf     <= 1'b0;
        end else if (ice) begin
            ihs_d <= isync[0];
            ivs_d <= isync[1];
            if (hs_neg) begin
                ihcount <= '0;
                sat     <= 1'b0;
            end else if (ihcount == HMAX) begin
                // Hold at the end; pixel HMAX was written once, later ones are dropped.
                sat <= 1'b1;
            end else begin
                ihcount <= ihcount + HONE;
            end
            if (hs_pos) ihs_beg <= ihcount;
            if (hs_neg) ihs_end <= ihcount;
            if (vs_neg)      line <= 1'b0;
            else if (hs_neg) line <= ~line;
            if (vs_neg)       ovf <= 1'b0;
            else if (ovf_evt) ovf <= 1'b1;
        end
    end

    // Line buffer: no reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (ice && !sat) mem[{line, ihcount}] <= irgb;
        if (oce)         brgb <= mem[{~line, ohcount}];
    end

    assign o_pos = isync[0] & ~ohs_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ohs_d   <= 1'b0;
            ohcount <= '0;
            phase   <= 1'b0;
            ohs     <= 1'b0;
        end else if (oce) begin
            ohs_d <= isync[0];
            if (o_pos) begin
                ohcount <= ihs_beg;
                phase   <= 1'b0;
            end else if (ohcount == ihs_end) begin
                ohcount <= '0;
                phase   <= ~phase;
            end else begin
                ohcount <= ohcount + HONE;
            end
            if (ohcount == ihs_end)      ohs <= 1'b0;
            else if (ohcount == ihs_beg) ohs <= 1'b1;
        end
    end

`ifdef SCANLINE_DIM_EN
    logic [CW-1:0] chan;

    always_comb begin
        dim_rgb = brgb;
        chan    = '0;
        if (phase && (sl_mode != 2'd0)) begin
            for (int c = 0; c < CH; c++) begin
                chan = brgb[c*CW +: CW];
                case (sl_mode)
                    2'd1:    chan = chan - (chan >> 2);
                    2'd2:    chan = chan >> 1;
                    default: chan = chan >> 2;
                endcase
                dim_rgb[c*CW +: CW] = chan;
            end
        end
    end
`else
    logic unused_dim;
    assign unused_dim = ^{sl_mode, phase};
    assign dim_rgb    = brgb;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            osync <= 2'b00;
            orgb  <= '0;
        end else if (novga) begin
            if (ice) begin
                orgb  <= irgb;
                osync <= {1'b1, ~^isync};
            end
        end else if (oce) begin
            orgb  <= dim_rgb;
            osync <= {isync[1], ohs};
        end
    end

endmodule

// File: tb/tb_scandoubler_sl.sv
// tb/tb_scandoubler_sl.sv - directed self-checking bench for scandoubler_sl

module tb_scandoubler_sl;
    localparam int HCW = 9;
    localparam int CH  = 3;
    localparam int CW  = 6;
    localparam int PW  = CH * CW;

    logic          clock   = 1'b0;
    logic          reset   = 1'b1;
    logic          novga   = 1'b0;
    logic [1:0]    sl_mode = 2'd0;
    logic          ice     = 1'b0;
    logic [1:0]    isync   = 2'b00;
    logic [PW-1:0] irgb    = '0;
    logic          oce     = 1'b0;
    logic [1:0]    osync;
    logic [PW-1:0] orgb;
    logic          ovf;

    int            nvec = 0;
    int            nerr = 0;
    int            g    = 0;
    int            cyc  = 0;
    logic          use_const = 1'b0;
    logic [PW-1:0] const_pix = '0;

    scandoubler_sl #(.HCW(HCW), .CH(CH), .CW(CW)) dut (
        .clock   (clock),
        .reset   (reset),
        .novga   (novga),
        .sl_mode (sl_mode),
        .ice     (ice),
        .isync   (isync),
        .irgb    (irgb),
        .oce     (oce),
        .osync   (osync),
        .orgb    (orgb),
        .ovf     (ovf)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One clock of the 448-pixel line generator: ice every second clock,
    // hsync high for generator counts 400..431.
    task automatic step();
        cyc++;
        if (cyc % 2 == 0) begin
            ice   = 1'b1;
            isync = {1'b0, (g >= 400 && g <= 431)};
            irgb  = use_const ? const_pix : PW'(g);
            g     = (g + 1) % 448;
        end else begin
            ice = 1'b0;
        end
        tick();
    endtask

    task automatic ice_cycle(input logic [1:0] s, input logic [PW-1:0] p);
        ice   = 1'b1;
        isync = s;
        irgb  = p;
        tick();
        ice = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        oce   = 1'b1;
        tick();
        tick();
        nvec++; if (osync !== 2'b00) begin nerr++; $display("FAIL reset_osync: got %b want 00", osync); end
        nvec++; if (orgb !== '0) begin nerr++; $display("FAIL reset_orgb: got %h want 0", orgb); end
        nvec++; if (ovf !== 1'b0) begin nerr++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_line_timing();
        int po, seq_bad, vs_bad, hs_hi, rises, rise_bad, run, run_bad;
        logic ph;
        seq_bad = 0; vs_bad = 0; hs_hi = 0; rises = 0; rise_bad = 0; run = 0; run_bad = 0;
        for (int i = 0; i < 4 * 896; i++) step();
        po = int'(orgb);
        ph = osync[0];
        for (int i = 0; i < 1792; i++) begin
            step();
            if (int'(orgb) != (po + 1) % 448) seq_bad++;
            if (osync[1] !== 1'b0) vs_bad++;
            if (osync[0] === 1'b1) begin
                hs_hi++;
                run++;
                if (!ph) begin
                    rises++;
                    if (orgb !== PW'(400)) rise_bad++;
                end
            end else begin
                if (ph && run != 0 && run != 32) run_bad++;
                run = 0;
            end
            po = int'(orgb);
            ph = osync[0];
        end
        nvec++; if (seq_bad != 0) begin nerr++; $display("FAIL line_seq: %0d non-consecutive pixels, want 0", seq_bad); end
        nvec++; if (vs_bad != 0) begin nerr++; $display("FAIL line_vsync: %0d samples high, want 0", vs_bad); end
        nvec++; if (hs_hi != 128) begin nerr++; $display("FAIL line_hs_total: got %0d want 128", hs_hi); end
        nvec++; if (rises != 4) begin nerr++; $display("FAIL line_hs_count: got %0d want 4", rises); end
        nvec++; if (rise_bad != 0) begin nerr++; $display("FAIL line_hs_pixel: %0d rises off pixel 400, want 0", rise_bad); end
        nvec++; if (run_bad != 0) begin nerr++; $display("FAIL line_hs_width: %0d pulses not 32 wide, want 0", run_bad); end
    endtask

    task automatic test_scanline();
        logic [PW-1:0] dimw;
        int n_full, n_bad, exp_full;
        logic active;
        use_const = 1'b1;
        const_pix = '1;
        for (int i = 0; i < 3 * 896; i++) step();
        for (int m = 0; m < 4; m++) begin
            sl_mode = 2'(m);
            case (m)
                1:       dimw = 18'h30C30;
                2:       dimw = 18'h1F7DF;
                3:       dimw = 18'h0F3CF;
                default: dimw = 18'h3FFFF;
            endcase
`ifdef SCANLINE_DIM_EN
            active = (m != 0);
`else
            active = 1'b0;
`endif
            exp_full = active ? 896 : 1792;
            step();
            step();
            n_full = 0;
            n_bad  = 0;
            for (int i = 0; i < 1792; i++) begin
                step();
                if (orgb === 18'h3FFFF) n_full++;
                else if (!active || orgb !== dimw) n_bad++;
            end
            nvec++; if (n_full != exp_full) begin nerr++; $display("FAIL scan_full_m%0d: got %0d want %0d", m, n_full, exp_full); end
            nvec++; if (n_bad != 0) begin nerr++; $display("FAIL scan_dim_m%0d: %0d wrong pixels, want 0 (dim %h)", m, n_bad, dimw); end
        end
        use_const = 1'b0;
        sl_mode   = 2'd0;
    endtask

    task automatic test_overflow();
        int first;
        ice_cycle(2'b10, '0);
        ice_cycle(2'b00, '0);
        ice_cycle(2'b01, '0);
        ice_cycle(2'b00, '0);
        first = -1;
        for (int k = 0; k < 600; k++) begin
            ice_cycle(2'b00, PW'(k));
            if (ovf === 1'b1 && first < 0) first = k;
        end
        nvec++; if (first != 511) begin nerr++; $display("FAIL ovf_rise: rose at count %0d want 511", first); end
        nvec++; if (dut.mem[1023] !== 18'd511) begin nerr++; $display("FAIL ovf_mem511: got %0d want 511", dut.mem[1023]); end
        nvec++; if (dut.mem[1022] !== 18'd510) begin nerr++; $display("FAIL ovf_mem510: got %0d want 510", dut.mem[1022]); end
        ice_cycle(2'b10, '0);
        ice_cycle(2'b00, '0);
        nvec++; if (ovf !== 1'b0) begin nerr++; $display("FAIL ovf_clear: got %b want 0", ovf); end
        ice_cycle(2'b01, '0);
        ice_cycle(2'b00, '0);
    endtask

    task automatic test_line_select();
        ice_cycle(2'b00, 18'h155);
        ice_cycle(2'b01, '0);
        ice_cycle(2'b00, '0);
        ice_cycle(2'b00, 18'h0AA);
        nvec++; if (dut.mem[0] !== 18'h0AA) begin nerr++; $display("FAIL sel_toggle: half0 got %h want 0aa", dut.mem[0]); end
        ice_cycle(2'b11, '0);
        ice_cycle(2'b00, '0);
        ice_cycle(2'b00, 18'h2AA);
        nvec++; if (dut.mem[0] !== 18'h2AA) begin nerr++; $display("FAIL sel_force_half0: got %h want 2aa", dut.mem[0]); end
        nvec++; if (dut.mem[512] !== 18'h155) begin nerr++; $display("FAIL sel_force_half1: got %h want 155", dut.mem[512]); end
    endtask

    task automatic test_async_reset();
        ice_cycle(2'b01, '0);
        ice_cycle(2'b00, '0);
        ice_cycle(2'b00, 18'h0F0);
        isync = 2'b10;
        tick();
        tick();
        nvec++; if (osync[1] !== 1'b1) begin nerr++; $display("FAIL pre_reset_vsync: got %b want 1", osync[1]); end
        #2;
        reset = 1'b1;
        #1;
        nvec++; if (osync !== 2'b00) begin nerr++; $display("FAIL async_osync: got %b want 00", osync); end
        nvec++; if (orgb !== '0) begin nerr++; $display("FAIL async_orgb: got %h want 0", orgb); end
        nvec++; if (ovf !== 1'b0) begin nerr++; $display("FAIL async_ovf: got %b want 0", ovf); end
        isync = 2'b00;
        tick();
        reset = 1'b0;
        ice_cycle(2'b00, 18'h123);
        nvec++; if (dut.mem[0] !== 18'h123) begin nerr++; $display("FAIL post_reset_half0: got %h want 123", dut.mem[0]); end
        nvec++; if (dut.mem[512] !== 18'h0F0) begin nerr++; $display("FAIL post_reset_half1: got %h want 0f0", dut.mem[512]); end
    endtask

    task automatic test_bypass();
        logic [1:0]    sv [4];
        logic [1:0]    ev [4];
        logic [PW-1:0] pv [4];
        sv[0] = 2'b01; ev[0] = 2'b10; pv[0] = 18'h12345;
        sv[1] = 2'b11; ev[1] = 2'b11; pv[1] = 18'h2ABCD;
        sv[2] = 2'b00; ev[2] = 2'b11; pv[2] = 18'h00F0F;
        sv[3] = 2'b10; ev[3] = 2'b10; pv[3] = 18'h3C3C3;
        novga = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ice   = 1'b1;
            isync = sv[i];
            irgb  = pv[i];
            tick();
            ice = 1'b0;
            nvec++; if (osync !== ev[i]) begin nerr++; $display("FAIL byp_osync_%0d: got %b want %b", i, osync, ev[i]); end
            nvec++; if (orgb !== pv[i]) begin nerr++; $display("FAIL byp_orgb_%0d: got %h want %h", i, orgb, pv[i]); end
            irgb = ~pv[i];
            tick();
            nvec++; if (orgb !== pv[i]) begin nerr++; $display("FAIL byp_hold_%0d: got %h want %h", i, orgb, pv[i]); end
        end
        novga = 1'b0;
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_scanline();
        test_overflow();
        test_line_select();
        test_async_reset();
        test_bypass();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
